// File: rtl/div16x16_seq.sv
// Sequential 16/16 restoring divider: one quotient bit per clock, fixed latency.
// Define DIV16_SIGNED_EN to compile in two's-complement support (signed_op, overflow).
module div16x16_seq (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        signed_op,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero,
  output logic        overflow,
  output logic        zflag,
  output logic        nflag
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [15:0] prem;
  logic [15:0] dvd_q;
  logic [15:0] dvs;
  logic [3:0]  cnt;
  logic        dz;

  logic [16:0] shifted;
  logic [16:0] trial;
  logic [15:0] acc_dvd;
  logic [15:0] acc_dvs;
  logic [15:0] q_fix;
  logic [15:0] r_fix;

`ifdef DIV16_SIGNED_EN
  logic qsign;
  logic rsign;
  logic ovf;
  logic acc_qs;
  logic acc_rs;
  logic acc_ovf;

  function automatic logic [15:0] neg16(input logic signed [15:0] v);
    return -v;
  endfunction

  // Operand magnitudes and result signs captured at the accepting edge.
  always_comb begin
    acc_dvd = (signed_op && dividend[15]) ? neg16(dividend) : dividend;
    acc_dvs = (signed_op && divisor[15])  ? neg16(divisor)  : divisor;
    acc_qs  = signed_op & (dividend[15] ^ divisor[15]);
    acc_rs  = signed_op & dividend[15];
    acc_ovf = signed_op & (dividend == 16'h8000) & (divisor == 16'hFFFF);
  end

  // Divide-by-zero keeps the preloaded results untouched.
  always_comb begin
    q_fix = dvd_q;
    r_fix = prem;
    if (!dz && qsign) q_fix = neg16(dvd_q);
    if (!dz && rsign) r_fix = neg16(prem);
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  always_comb begin
    acc_dvd = dividend;
    acc_dvs = divisor;
    q_fix   = dvd_q;
    r_fix   = prem;
  end
`endif

  // Shift {prem, dvd_q} left and trial-subtract in 17 bits.
  always_comb begin
    shifted = {prem, dvd_q[15]};
    trial   = shifted - {1'b0, dvs};
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      done      <= 1'b0;
      quotient  <= 16'h0000;
      remainder <= 16'h0000;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      zflag     <= 1'b0;
      nflag     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == 16'h0000) begin
              dvd_q <= 16'hFFFF;
              prem  <= dividend;
              dz    <= 1'b1;
`ifdef DIV16_SIGNED_EN
              qsign <= 1'b0;
              rsign <= 1'b0;
              ovf   <= 1'b0;
`endif
              state <= FIX;
            end else begin
              dvd_q <= acc_dvd;
              dvs   <= acc_dvs;
              prem  <= 16'h0000;
              dz    <= 1'b0;
              cnt   <= 4'd15;
`ifdef DIV16_SIGNED_EN
              qsign <= acc_qs;
              rsign <= acc_rs;
              ovf   <= acc_ovf;
`endif
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[16]) begin
            prem  <= trial[15:0];
            dvd_q <= {dvd_q[14:0], 1'b1};
          end else begin
            prem  <= shifted[15:0];
            dvd_q <= {dvd_q[14:0], 1'b0};
          end
          if (cnt == 4'd0) state <= FIX;
          else             cnt   <= cnt - 4'd1;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          div_zero  <= dz;
`ifdef DIV16_SIGNED_EN
          overflow  <= ovf;
`else
          overflow  <= 1'b0;
`endif
          zflag     <= (q_fix == 16'h0000);
          nflag     <= q_fix[15];
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16x16_seq.sv
// Scoreboard bench for div16x16_seq: expected results come from an integer reference model.
module tb_div16x16_seq;

`ifdef DIV16_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [15:0] dividend = 16'h0;
  logic [15:0] divisor = 16'h0;
  logic        busy, done, div_zero, overflow, zflag, nflag;
  logic [15:0] quotient, remainder;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  exp_t scb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  div16x16_seq dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero),
    .overflow(overflow), .zflag(zflag), .nflag(nflag)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) if (done) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sop);
    exp_t e;
    int   sa, sd;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (b == 16'h0) begin
      e.q  = 16'hFFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (SGN && sop) begin
      sa = $signed(a);
      sd = $signed(b);
      if (sa == -32768 && sd == -1) begin
        e.q  = 16'h8000;
        e.r  = 16'h0000;
        e.ov = 1'b1;
      end else begin
        e.q = 16'(sa / sd);
        e.r = 16'(sa % sd);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.z = (e.q == 16'h0);
    e.n = e.q[15];
    return e;
  endfunction

  // extra_at: cycle in which a second (to be ignored) start with 9/3 is pulsed.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sop,
                        input int lat, input int extra_at);
    exp_t e;
    int   cyc;
    int   bcnt;
    bit   got;
    scb.push_back(model(a, b, sop));
    @(negedge CLOCK);
    dividend  = a;
    divisor   = b;
    signed_op = sop;
    start     = 1'b1;
    bcnt = 0;
    got  = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge CLOCK);
      if (busy) bcnt++;
      if (cyc == extra_at) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
      end else begin
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    e = scb.pop_front();
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("latency", cyc, lat);
      chk("busy_cycles", bcnt, lat);
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_zero", div_zero, e.dz);
      chk("overflow", overflow, e.ov);
      chk("zflag", zflag, e.z);
      chk("nflag", nflag, e.n);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          dsnap;

    repeat (3) @(negedge CLOCK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", {div_zero, overflow, zflag, nflag}, 0);
    RESET_N = 1'b1;

    run_op(16'd100, 16'd7, 1'b0, 18, 0);
    chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2);
    run_op(16'hFFFF, 16'h0001, 1'b0, 18, 0);
    run_op(16'd3, 16'd10, 1'b0, 18, 0);
    run_op(16'h04D2, 16'h0000, 1'b0, 2, 0);
    run_op(16'd8, 16'd2, 1'b0, 18, 0);
    chk("q_8_2", quotient, 4);
    run_op(16'hFFF9, 16'd2, 1'b1, 18, 0);
    run_op(16'h8000, 16'hFFFF, 1'b1, 18, 0);
    run_op(16'hFFF9, 16'd2, 1'b0, 18, 0);
    chk("q_fff9_2_u", quotient, 16'h7FFC);
    run_op(16'h8000, 16'h0000, 1'b1, 2, 0);
    run_op(16'h8001, 16'h0003, 1'b1, 18, 0);
    run_op(16'd500, 16'd3, 1'b0, 18, 5);
    chk("q_500_3", quotient, 166);
    chk("r_500_3", remainder, 2);

    // start raised during the DONE cycle must not be accepted
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge CLOCK);
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 12));
      if (rb == 16'h0 && i == 7) rb = 16'd1;
      run_op(ra, rb, 1'($urandom), (rb == 16'h0) ? 2 : 18, 0);
    end

    // abort mid-CALC with reset
    run_op(16'hFFFF, 16'h0001, 1'b0, 18, 0);
    @(negedge CLOCK);
    dividend = 16'd500;
    divisor  = 16'd3;
    start    = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLOCK);
      start = 1'b0;
      if (c == 8) RESET_N = 1'b0;
    end
    @(negedge CLOCK);
    dsnap = done_cnt;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_flags", {div_zero, overflow, zflag, nflag}, 0);
    RESET_N = 1'b1;
    repeat (30) @(negedge CLOCK);
    chk("abort_no_done", done_cnt, dsnap);
    chk("abort_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
